pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Multicycle PC/fetch controller for the RV32I core. Owns the program counter and
//  issues instruction fetches over a req/ack handshake. Presents each fetched word to
//  the decode/execute datapath, which includes the B_type branch unit. On retire it
//  selects the next PC from three sources: the branch unit's next address, the jump
//  target, or PC+4. It also traps on misaligned targets and fetch timeouts.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  TIMEOUT      16             max cycles in FETCH without imem_ack before trap (>=2)
//  CNT_W        32             width of retired-instruction counter
// PORTS
//  clk          in   1      core clock, all state on posedge
//  reset        in   1      asynchronous, active-low reset (0 = in reset)
//  iaddr        out  32     current PC / fetch address
//  imem_req     out  1      fetch request, held until imem_ack
//  imem_ack     in   1      fetch response valid; idata sampled this cycle
//  idata        in   32     fetched instruction word
//  instr        out  32     registered instruction presented to datapath
//  instr_valid  out  1      instr is valid and executing
//  exec_done    in   1      datapath retires instr this cycle
//  br_next      in   32     B_type next address (iaddr_val) for current instr
//  jmp_target   in   32     JAL/JALR target computed by datapath
//  halt_req     in   1      debug halt; honoured at instruction boundary
//  halted       out  1      in HALT state
//  err          out  1      sticky trap flag
//  err_code     out  2      riscv_pkg::seq_err_e: NONE, MISALIGN, TIMEOUT
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, iaddr=RESET_PC, instr=0, outputs 0, counters 0.
//  States (seq_state_e): IDLE, FETCH, EXEC, HALT, ERROR.
//  IDLE: one cycle after reset release -> FETCH, unconditionally.
//  FETCH: imem_req=1, iaddr stable. On imem_ack: instr<=idata, go EXEC, toctr<=0.
//   Otherwise toctr++. When toctr==TIMEOUT-1 with no ack -> ERROR, err_code=TIMEOUT.
//   An ack in the same cycle as the limit wins; no trap.
//  EXEC: instr_valid=1, imem_req=0. On exec_done, select next PC by instr[6:0]:
//   OP_BRANCH (1100011) -> br_next. OP_JAL/OP_JALR -> jmp_target. Else iaddr+4,
//   wrapping mod 2^32.
//   If next[1:0]!=2'b00 -> ERROR, err_code=MISALIGN; iaddr keeps the faulting
//   instr's PC and instret is not incremented.
//   Else iaddr<=next and instret++ (wraps mod 2^CNT_W). Then HALT if halt_req, else FETCH.
//  Min throughput: 2 cycles/instr (ack in first FETCH cycle, done in first EXEC cycle).
//  halt_req in FETCH/EXEC is deferred to retire; an in-flight fetch is never aborted.
//  HALT: halted=1, no requests; halt_req=0 -> FETCH at current iaddr.
//  ERROR: err=1, all requests 0, iaddr frozen; exit only via reset.
//  exec_done outside EXEC and imem_ack outside FETCH are ignored.
//  Reset mid-fetch drops the transaction; imem must tolerate req falling without ack.
// STRUCTURE
//  riscv_pkg additions: seq_state_e, seq_err_e, OP_BRANCH/OP_JAL/OP_JALR localparams.
//  One sub-module: fetch_timeout_ctr (clear/enable/expired, width $clog2(TIMEOUT)).
//  Next-PC mux is always_comb in this module; state and PC in one always_ff.
// TESTING
//  1 Reset, ack every FETCH cycle, 3 ADDI -> iaddr 0,4,8,C; instret=3; 2 cyc/instr.
//  2 BEQ at 0x10, br_next=0x40 -> iaddr=0x40. BEQ, br_next=0x14 -> iaddr=0x14.
//  3 JAL with jmp_target=0x102 -> ERROR, err_code=MISALIGN, iaddr=faulting PC, instret unchanged.
//  4 imem_ack withheld, TIMEOUT=16 -> err=1 after 16 FETCH cycles; ack on cycle 16 -> no trap.
//  5 halt_req with exec_done in same cycle -> PC updated, halted next cycle; drop -> FETCH.
//  6 reset low mid-FETCH at PC 0x20 -> iaddr=RESET_PC, imem_req=0 immediately (async).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core types: fetch-sequencer states, trap codes and the opcodes
// the sequencer decodes to choose its next PC.
package riscv_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_FETCH = 3'd1,
    SEQ_EXEC  = 3'd2,
    SEQ_HALT  = 3'd3,
    SEQ_ERROR = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } seq_err_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive un-acknowledged fetch cycles; expired_o flags the last
// cycle the sequencer may wait before trapping.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multicycle PC/fetch controller: owns the PC, fetches over req/ack, holds the
// instruction while it executes and picks the next PC on retire.
module pc_fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      iaddr,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      idata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic [31:0]      br_next,
  input  logic [31:0]      jmp_target,
  input  logic             halt_req,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instret
);

  seq_state_e       state_q;
  seq_err_e         err_code_q;
  logic [31:0]      iaddr_q;
  logic [31:0]      instr_q;
  logic             req_q;
  logic             valid_q;
  logic             halted_q;
  logic             err_q;
  logic [CNT_W-1:0] instret_q;
  logic [31:0]      next_pc_d;
  logic             to_expired;

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   ((state_q != SEQ_FETCH) || imem_ack),
    .enable_i  (state_q == SEQ_FETCH),
    .expired_o (to_expired)
  );

  // NOTE: next_pc_d is assigned on every path, so no latch is inferred.
  always_comb begin
    next_pc_d = iaddr_q + 32'd4;
    case (instr_q[6:0])
      OP_BRANCH:       next_pc_d = br_next;
      OP_JAL, OP_JALR: next_pc_d = jmp_target;
      default:         next_pc_d = iaddr_q + 32'd4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEQ_IDLE;
      iaddr_q    <= RESET_PC;
      instr_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      instret_q  <= '0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          state_q <= SEQ_FETCH;
          req_q   <= 1'b1;
        end
        SEQ_FETCH: begin
          // An ack on the limit cycle still completes the fetch.
          if (imem_ack) begin
            instr_q <= idata;
            state_q <= SEQ_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else if (to_expired) begin
            state_q    <= SEQ_ERROR;
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end
        end
        SEQ_EXEC: begin
          if (exec_done) begin
            valid_q <= 1'b0;
            if (pc_misaligned(next_pc_d)) begin
              state_q    <= SEQ_ERROR;
              err_q      <= 1'b1;
              err_code_q <= ERR_MISALIGN;
            end else begin
              iaddr_q   <= next_pc_d;
              instret_q <= instret_q + CNT_W'(1);
              if (halt_req) begin
                state_q  <= SEQ_HALT;
                halted_q <= 1'b1;
              end else begin
                state_q <= SEQ_FETCH;
                req_q   <= 1'b1;
              end
            end
          end
        end
        SEQ_HALT: begin
          if (!halt_req) begin
            state_q  <= SEQ_FETCH;
            halted_q <= 1'b0;
            req_q    <= 1'b1;
          end
        end
        SEQ_ERROR: begin
          state_q <= SEQ_ERROR;
        end
        default: begin
          state_q <= SEQ_ERROR;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign iaddr       = iaddr_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_pc_fetch_sequencer;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [31:0] W_ADDI = 32'h0010_0093;
  localparam logic [31:0] W_BEQ  = 32'h0000_0063;
  localparam logic [31:0] W_JAL  = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] iaddr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] idata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic [31:0] br_next = '0;
  logic [31:0] jmp_target = '0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .iaddr       (iaddr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .idata       (idata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .br_next     (br_next),
    .jmp_target  (jmp_target),
    .halt_req    (halt_req),
    .halted      (halted),
    .err         (err),
    .err_code    (err_code),
    .instret     (instret)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h @%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: what the sequencer is doing, how long it has waited,
  // and what it has retired.
  typedef enum int {M_BOOT, M_WAIT_IMEM, M_RUN, M_PARKED, M_DEAD} m_mode_e;
  m_mode_e     m_mode    = M_BOOT;
  int unsigned m_waited  = 0;
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_instr   = '0;
  logic [31:0] m_retired = '0;
  logic [1:0]  m_code    = 2'd0;

  function automatic logic [31:0] rule_next(input logic [31:0] word, input logic [31:0] pc,
                                            input logic [31:0] br, input logic [31:0] jt);
    if (word[6:0] == 7'h63) return br;
    if (word[6:0] == 7'h6F || word[6:0] == 7'h67) return jt;
    return pc + 32'd4;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [31:0] nxt;
    if (!reset) begin
      m_mode = M_BOOT; m_waited = 0; m_pc = RESET_PC;
      m_instr = '0; m_retired = '0; m_code = 2'd0;
    end else begin
      case (m_mode)
        M_BOOT: begin m_mode = M_WAIT_IMEM; m_waited = 0; end
        M_WAIT_IMEM: begin
          if (imem_ack) begin
            m_instr = idata; m_mode = M_RUN; m_waited = 0;
          end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin m_mode = M_DEAD; m_code = 2'd2; end
          end
        end
        M_RUN: if (exec_done) begin
          nxt = rule_next(m_instr, m_pc, br_next, jmp_target);
          if (nxt % 4 != 0) begin
            m_mode = M_DEAD; m_code = 2'd1;
          end else begin
            m_pc = nxt;
            m_retired = m_retired + 32'd1;
            m_mode = halt_req ? M_PARKED : M_WAIT_IMEM;
            m_waited = 0;
          end
        end
        M_PARKED: if (!halt_req) begin m_mode = M_WAIT_IMEM; m_waited = 0; end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("cyc_iaddr",   iaddr,       m_pc);
      check("cyc_req",     imem_req,    m_mode == M_WAIT_IMEM);
      check("cyc_valid",   instr_valid, m_mode == M_RUN);
      check("cyc_halted",  halted,      m_mode == M_PARKED);
      check("cyc_err",     err,         m_mode == M_DEAD);
      check("cyc_errcode", err_code,    m_code);
      check("cyc_instr",   instr,       m_instr);
      check("cyc_instret", instret,     m_retired);
    end
  end

  task automatic step(input logic ack, input logic [31:0] data, input logic done,
                      input logic [31:0] br, input logic [31:0] jt, input logic halt);
    imem_ack = ack; idata = data; exec_done = done;
    br_next = br; jmp_target = jt; halt_req = halt;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Leaves the sequencer in its first FETCH cycle at RESET_PC.
  task automatic boot();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle();
  endtask

  task automatic run_instr(input logic [31:0] word, input logic [31:0] br,
                           input logic [31:0] jt, input logic halt);
    step(1'b1, word, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b1, br, jt, halt);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(31, 0) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic rand_episode(input int cycles, input int ack_den);
    boot();
    for (int i = 0; i < cycles; i++) begin
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(4, 0))
        0:       w[6:0] = 7'h13;
        1:       w[6:0] = 7'h63;
        2:       w[6:0] = 7'h6F;
        3:       w[6:0] = 7'h67;
        default: w[6:0] = 7'h03;
      endcase
      step($urandom_range(ack_den - 1, 0) == 0, w, $urandom_range(1, 0) == 1,
           rand_target(), rand_target(), $urandom_range(7, 0) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    boot();
    check("boot_iaddr",   iaddr,    32'h0);
    check("boot_req",     imem_req, 1'b1);
    check("boot_instret", instret,  32'd0);

    // Straight-line code, two cycles per instruction.
    run_instr(W_ADDI, '0, '0, 1'b0);  check("addi1_pc", iaddr, 32'h4);
    run_instr(W_ADDI, '0, '0, 1'b0);  check("addi2_pc", iaddr, 32'h8);
    run_instr(W_ADDI, '0, '0, 1'b0);  check("addi3_pc", iaddr, 32'hC);
    check("addi_instret", instret, 32'd3);

    // Branches take br_next whether it jumps forward or falls through.
    run_instr(W_ADDI, '0, '0, 1'b0);            check("pc_0x10", iaddr, 32'h10);
    run_instr(W_BEQ, 32'h40, 32'h88, 1'b0);     check("beq_taken", iaddr, 32'h40);
    run_instr(W_BEQ, 32'h14, 32'h88, 1'b0);     check("beq_fall", iaddr, 32'h14);
    check("beq_instret", instret, 32'd6);
    check("model_pc_pin", m_pc, 32'h14);
    check("model_ret_pin", m_retired, 32'd6);

    // Halt requested during fetch is deferred; retire with halt parks.
    step(1'b1, W_ADDI, 1'b0, '0, '0, 1'b1);
    check("halt_defer_valid", instr_valid, 1'b1);
    check("halt_defer_halted", halted, 1'b0);
    step(1'b0, '0, 1'b1, '0, '0, 1'b1);
    check("halt_pc", iaddr, 32'h18);
    check("halt_flag", halted, 1'b1);
    check("halt_req_low", imem_req, 1'b0);
    step(1'b1, W_ADDI, 1'b1, '0, '0, 1'b1);
    check("halt_hold", halted, 1'b1);
    check("halt_instret", instret, 32'd7);
    idle();
    check("unhalt_flag", halted, 1'b0);
    check("unhalt_req", imem_req, 1'b1);
    run_instr(W_ADDI, '0, '0, 1'b0);
    run_instr(W_ADDI, '0, '0, 1'b0);
    check("pc_0x20", iaddr, 32'h20);

    // Asynchronous reset in the middle of a pending fetch.
    idle();
    check("midfetch_req", imem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pc", iaddr, RESET_PC);
    check("async_rst_req", imem_req, 1'b0);
    check("async_rst_instret", instret, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Misaligned jump traps at the faulting PC without retiring.
    run_instr(W_ADDI, '0, '0, 1'b0);
    run_instr(W_JAL, 32'h0, 32'h102, 1'b0);
    check("mis_err", err, 1'b1);
    check("mis_code", err_code, 2'd1);
    check("mis_pc", iaddr, 32'h4);
    check("mis_instret", instret, 32'd1);
    step(1'b1, W_ADDI, 1'b1, '0, '0, 1'b0);
    check("mis_frozen_pc", iaddr, 32'h4);
    check("mis_no_req", imem_req, 1'b0);

    // Timeout: sixteen unanswered FETCH cycles trap, an ack on the 16th does not.
    boot();
    repeat (TIMEOUT - 1) idle();
    check("to_not_yet", err, 1'b0);
    check("to_still_req", imem_req, 1'b1);
    idle();
    check("to_err", err, 1'b1);
    check("to_code", err_code, 2'd2);
    check("to_req_low", imem_req, 1'b0);
    boot();
    repeat (TIMEOUT - 1) idle();
    step(1'b1, W_ADDI, 1'b0, '0, '0, 1'b0);
    check("to_late_ack_err", err, 1'b0);
    check("to_late_ack_valid", instr_valid, 1'b1);
    check("to_late_ack_instr", instr, W_ADDI);
    step(1'b0, '0, 1'b1, '0, '0, 1'b0);
    check("to_late_ack_pc", iaddr, 32'h4);

    rand_episode(400, 2);
    rand_episode(400, 2);
    rand_episode(400, 3);
    rand_episode(400, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
